updown_counter_mod: RTL and testbench
=====================================

# updown_counter_mod

Parametrised, synchronous up/down counter with programmable modulo limit, parallel load, synchronous clear and selectable terminal behaviour (wrap, saturate, one-shot). It generalises the 12-bit free-running enable counter used across the gyro tester IP. Uses include sample-period dividers, timeouts and frame/burst counting. Terminal events produce a registered one-cycle pulse and a sticky overflow flag for status registers.

## Interface
- WIDTH, 12, counter width in bits (≥2)
- RESET_VALUE, 0, count value after reset (WIDTH bits)
- clock  in  1  rising-edge clock
- reset_n  in  1  reset, synchronous, active-low
- enable  in  1  count one step this cycle
- clear  in  1  synchronous clear
- load  in  1  parallel load strobe
- load_value  in  WIDTH  value written on load
- dir  in  1  1 = up, 0 = down; sampled each step
- limit  in  WIDTH  modulo limit; count range 0..limit
- mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 reserved (behaves as wrap)
- count  out  WIDTH  registered count
- at_terminal  out  1  count is at terminal value for current dir
- tc_pulse  out  1  one-cycle pulse, registered, on a terminal event
- done  out  1  one-shot finished; count frozen
- overflow  out  1  sticky: terminal event occurred

## Operation
- Terminal condition T: up → count ≥ limit; down → count == 0. at_terminal = T, combinational from count, dir and limit.
- Priority per clock edge: reset_n low > clear > load > enable step > hold.
- Reset (reset_n low at edge): count = RESET_VALUE, tc_pulse = 0, done = 0, overflow = 0.
- clear: count = 0, done = 0, overflow = 0, tc_pulse = 0. Load and enable ignored that cycle.
- load: count = load_value, done = 0, tc_pulse = 0, overflow unchanged. load_value > limit is accepted unchanged.
- Enable step, T false: count ± 1 per dir, modulo 2^WIDTH arithmetic never triggered since T guards both ends.
- Enable step, T true (terminal event), tc_pulse = 1 next cycle:
  - wrap: up → count = 0; down → count = limit. overflow = 1.
  - saturate: count holds. overflow = 1. Every enabled cycle at T is a terminal event, so tc_pulse repeats.
  - one-shot: count holds, done = 1, overflow unchanged. While done = 1, enable is ignored and no further tc_pulse occurs. Only clear, load or reset releases it.
- limit = 0: up and down both at T permanently. Wrap gives count 0 and a tc_pulse every enabled cycle.
- limit change while running: takes effect on the next step. If count > new limit while counting up, the next step is a terminal event.
- dir change between steps: takes effect immediately, and T is re-evaluated with the new dir.
- enable low: count, done and overflow hold, and tc_pulse = 0.

## Timing
- All state registered on clock rising edge. No asynchronous paths, and reset is synchronous only.
- count updates 1 cycle after the qualifying enable, load or clear edge.
- tc_pulse is high for exactly the cycle following the terminal-event edge, coincident with the post-event count value.
- done and overflow assert in the same cycle as tc_pulse.
- at_terminal has zero latency from count, combinational, with no registered delay.
- Reset asserted mid-count or mid-one-shot: all outputs take reset values on the next edge, irrespective of other inputs.

## Test plan
- Reset: WIDTH = 4, RESET_VALUE = 5, reset_n low 1 edge with enable = 1 → count = 5, tc_pulse = 0, done = 0, overflow = 0.
- Up wrap: WIDTH = 4, limit = 9, mode = 00, dir = 1, enable held from 0 → 0,1,…,9,0. tc_pulse high only in the cycle count returns to 0, and overflow latches 1. Repeat with dir = 0 from 2 → 2,1,0,9.
- Saturate: limit = 15, mode = 01, load 14, enable 3 cycles → 15,15,15. tc_pulse high on 2 consecutive cycles and overflow = 1. clear → count 0, overflow 0.
- One-shot: mode = 10, dir = 0, load 3, enable continuous → 2,1,0, then hold at 0. done = 1 with a single tc_pulse, and further enables change nothing. load 7 → done = 0 and counting resumes 6,5….
- Priority: clear = load = enable = 1 with count = 4 → count = 0. load = enable = 1 with load_value = 8 → count = 8, no step.
- Edge cases: limit = 0, wrap, enable held → count stays 0 and tc_pulse high every cycle. Load 12 with limit = 9, dir = 1, enable → count = 0 and tc_pulse = 1. Reset mid one-shot → done = 0.

Source files
------------

// File: rtl/updown_counter_mod_if.sv
// updown_counter_mod_if
//   Control/status bundle for updown_counter_mod.
//   master : drives enable, clear, load, load_value, dir, limit, mode;
//            observes count, at_terminal, tc_pulse, done, overflow.
//   slave  : the counter itself (mirror directions).
interface updown_counter_mod_if #(
    parameter int unsigned WIDTH = 12
);
    logic             enable;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             dir;
    logic [WIDTH-1:0] limit;
    logic [1:0]       mode;
    logic [WIDTH-1:0] count;
    logic             at_terminal;
    logic             tc_pulse;
    logic             done;
    logic             overflow;

    modport master (
        output enable, clear, load, load_value, dir, limit, mode,
        input  count, at_terminal, tc_pulse, done, overflow
    );

    modport slave (
        input  enable, clear, load, load_value, dir, limit, mode,
        output count, at_terminal, tc_pulse, done, overflow
    );
endinterface

// File: rtl/updown_counter_mod.sv
// updown_counter_mod
//   Synchronous up/down counter, range 0..limit, with parallel load,
//   synchronous clear and wrap / saturate / one-shot terminal behaviour.
//   Ports:
//     clock   : rising-edge clock
//     reset_n : synchronous active-low reset
//     bus     : updown_counter_mod_if.slave
//               inputs  enable, clear, load, load_value, dir, limit, mode
//               outputs count, at_terminal (combinational), tc_pulse,
//                       done, overflow (all registered)
module updown_counter_mod #(
    parameter int unsigned          WIDTH       = 12,
    parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    updown_counter_mod_if.slave  bus
);

    typedef enum logic [1:0] {
        MODE_WRAP     = 2'b00,
        MODE_SATURATE = 2'b01,
        MODE_ONESHOT  = 2'b10,
        MODE_RESERVED = 2'b11
    } mode_e;

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_pulse_q, tc_pulse_d;
    logic             done_q, done_d;
    logic             overflow_q, overflow_d;
    logic             terminal;
    mode_e            mode;

    assign mode = mode_e'(bus.mode);

    // Terminal test uses >= so a count left above a lowered limit (or loaded
    // above it) still terminates on the next up step.
    always_comb begin
        if (bus.dir) begin
            terminal = (count_q >= bus.limit);
        end else begin
            terminal = (count_q == '0);
        end
    end

    always_comb begin
        count_d    = count_q;
        done_d     = done_q;
        overflow_d = overflow_q;
        tc_pulse_d = 1'b0;

        if (bus.clear) begin
            count_d    = '0;
            done_d     = 1'b0;
            overflow_d = 1'b0;
        end else if (bus.load) begin
            count_d = bus.load_value;
            done_d  = 1'b0;
        end else if (bus.enable && !done_q) begin
            if (!terminal) begin
                if (bus.dir) begin
                    count_d = count_q + WIDTH'(1);
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end else begin
                tc_pulse_d = 1'b1;
                unique case (mode)
                    MODE_SATURATE: begin
                        overflow_d = 1'b1;
                    end
                    MODE_ONESHOT: begin
                        done_d = 1'b1;
                    end
                    MODE_WRAP, MODE_RESERVED: begin
                        overflow_d = 1'b1;
                        count_d    = bus.dir ? '0 : bus.limit;
                    end
                    default: begin
                        overflow_d = 1'b1;
                        count_d    = bus.dir ? '0 : bus.limit;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q    <= RESET_VALUE;
            tc_pulse_q <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            tc_pulse_q <= tc_pulse_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.count       = count_q;
    assign bus.at_terminal = terminal;
    assign bus.tc_pulse    = tc_pulse_q;
    assign bus.done        = done_q;
    assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_updown_counter_mod.sv
// tb_updown_counter_mod
//   Directed test of updown_counter_mod (WIDTH=4, RESET_VALUE=5) against an
//   integer reference model plus hand-computed literal expectations.
module tb_updown_counter_mod;

    localparam int W = 4;

    logic clock;
    logic reset_n;

    updown_counter_mod_if #(.WIDTH(W)) bus ();

    updown_counter_mod #(
        .WIDTH       (W),
        .RESET_VALUE (4'd5)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: plain integer state updated from the rules of operation.
    int m_count;
    bit m_tc, m_done, m_ovf;
    bit m_valid = 1'b0;

    always @(posedge clock) begin
        int c, lim;
        bit at_t;
        c   = m_count;
        lim = int'(bus.limit);
        m_tc = 1'b0;
        if (!reset_n) begin
            m_count = 5;
            m_done  = 1'b0;
            m_ovf   = 1'b0;
            m_valid = 1'b1;
        end else if (bus.clear) begin
            m_count = 0;
            m_done  = 1'b0;
            m_ovf   = 1'b0;
        end else if (bus.load) begin
            m_count = int'(bus.load_value);
            m_done  = 1'b0;
        end else if (bus.enable && !m_done) begin
            at_t = bus.dir ? (c >= lim) : (c == 0);
            if (!at_t) begin
                m_count = bus.dir ? c + 1 : c - 1;
            end else begin
                m_tc = 1'b1;
                if (bus.mode == 2'b10) begin
                    m_done = 1'b1;
                end else if (bus.mode == 2'b01) begin
                    m_ovf = 1'b1;
                end else begin
                    m_ovf   = 1'b1;
                    m_count = bus.dir ? 0 : lim;
                end
            end
        end
    end

    // Per-cycle compare, mid-cycle.
    always @(negedge clock) begin
        if (m_valid) begin
            check("model_count",    int'(bus.count), m_count);
            check("model_tc_pulse", int'(bus.tc_pulse), int'(m_tc));
            check("model_done",     int'(bus.done), int'(m_done));
            check("model_overflow", int'(bus.overflow), int'(m_ovf));
            check("model_at_terminal", int'(bus.at_terminal),
                  int'(bus.dir ? (m_count >= int'(bus.limit)) : (m_count == 0)));
        end
    end

    // One clock edge; returns 1 time unit after it so outputs are settled.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic lit(input string name, input int c, input int tc, input int dn, input int ov);
        check({name, "_count"}, int'(bus.count), c);
        check({name, "_tc"},    int'(bus.tc_pulse), tc);
        check({name, "_done"},  int'(bus.done), dn);
        check({name, "_ovf"},   int'(bus.overflow), ov);
    endtask

    int up_seq [10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
    int dn_seq [3]  = '{1, 0, 9};

    initial begin
        reset_n        = 1'b0;
        bus.enable     = 1'b1;
        bus.clear      = 1'b0;
        bus.load       = 1'b0;
        bus.load_value = '0;
        bus.dir        = 1'b1;
        bus.limit      = 4'd9;
        bus.mode       = 2'b00;

        // Reset with enable high
        step();
        lit("reset", 5, 0, 0, 0);

        // Up wrap from 0, limit 9
        reset_n   = 1'b1;
        bus.clear = 1'b1;
        step();
        lit("clear0", 0, 0, 0, 0);
        bus.clear = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("upwrap_count", int'(bus.count), up_seq[i]);
            check("upwrap_tc", int'(bus.tc_pulse), (i == 9) ? 1 : 0);
            if (i == 8) check("upwrap_at_term", int'(bus.at_terminal), 1);
        end
        check("upwrap_ovf", int'(bus.overflow), 1);

        // Down wrap from 2 (load wins over enable)
        bus.dir        = 1'b0;
        bus.load       = 1'b1;
        bus.load_value = 4'd2;
        step();
        lit("dnload", 2, 0, 0, 1);
        bus.load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("dnwrap_count", int'(bus.count), dn_seq[i]);
            check("dnwrap_tc", int'(bus.tc_pulse), (i == 2) ? 1 : 0);
        end

        // Saturate
        bus.limit      = 4'd15;
        bus.mode       = 2'b01;
        bus.dir        = 1'b1;
        bus.load       = 1'b1;
        bus.load_value = 4'd14;
        step();
        bus.load = 1'b0;
        step(); lit("sat1", 15, 0, 0, 1);
        step(); lit("sat2", 15, 1, 0, 1);
        step(); lit("sat3", 15, 1, 0, 1);
        bus.clear = 1'b1;
        step(); lit("satclr", 0, 0, 0, 0);
        bus.clear = 1'b0;

        // One-shot down from 3
        bus.mode       = 2'b10;
        bus.dir        = 1'b0;
        bus.load       = 1'b1;
        bus.load_value = 4'd3;
        step();
        bus.load = 1'b0;
        step(); lit("os1", 2, 0, 0, 0);
        step(); lit("os2", 1, 0, 0, 0);
        step(); lit("os3", 0, 0, 0, 0);
        step(); lit("os_term", 0, 1, 1, 0);
        step(); lit("os_hold1", 0, 0, 1, 0);
        step(); lit("os_hold2", 0, 0, 1, 0);
        bus.load       = 1'b1;
        bus.load_value = 4'd7;
        step(); lit("os_reload", 7, 0, 0, 0);
        bus.load = 1'b0;
        step(); lit("os_run1", 6, 0, 0, 0);
        step(); lit("os_run2", 5, 0, 0, 0);

        // Priority
        bus.load       = 1'b1;
        bus.load_value = 4'd4;
        step();
        bus.clear = 1'b1;
        step(); lit("pri_clear", 0, 0, 0, 0);
        bus.clear      = 1'b0;
        bus.load_value = 4'd8;
        step(); lit("pri_load", 8, 0, 0, 0);
        bus.load = 1'b0;

        // limit 0, wrap: 8 >= 0 terminates immediately, then stays at 0
        bus.mode  = 2'b00;
        bus.dir   = 1'b1;
        bus.limit = 4'd0;
        step(); lit("lim0_a", 0, 1, 0, 1);
        step(); lit("lim0_b", 0, 1, 0, 1);
        bus.dir = 1'b0;
        step(); lit("lim0_dn", 0, 1, 0, 1);
        bus.mode = 2'b11;
        step(); lit("lim0_rsvd", 0, 1, 0, 1);

        // Load above limit, counting up terminates on next step
        bus.mode       = 2'b00;
        bus.dir        = 1'b1;
        bus.limit      = 4'd9;
        bus.load       = 1'b1;
        bus.load_value = 4'd12;
        step(); lit("over_load", 12, 0, 0, 1);
        bus.load = 1'b0;
        step(); lit("over_step", 0, 1, 0, 1);

        // Reset mid one-shot
        bus.mode       = 2'b10;
        bus.dir        = 1'b0;
        bus.load       = 1'b1;
        bus.load_value = 4'd1;
        step();
        bus.load = 1'b0;
        step();
        step(); lit("os2_done", 0, 1, 1, 1);
        reset_n = 1'b0;
        step(); lit("reset_mid", 5, 0, 0, 0);
        reset_n = 1'b1;
        step(); lit("post_reset", 4, 0, 0, 0);

        @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
